// File: rtl/tmds_timing_ctrl.sv
// Video timing sequencer for the TMDS output path.
// Produces hsync/vsync/de for the channel encoders and a pixel request with
// coordinates one cycle ahead of de, so a registered pixel source lines up.
// Frames start and stop only on frame boundaries.
module tmds_timing_ctrl #(
    parameter int       H_SYNC   = 96,
    parameter int       H_BACK   = 48,
    parameter int       H_ACTIVE = 640,
    parameter int       H_FRONT  = 16,
    parameter int       V_SYNC   = 2,
    parameter int       V_BACK   = 33,
    parameter int       V_ACTIVE = 480,
    parameter int       V_FRONT  = 10,
    parameter logic     SYNC_POL = 1'b0,
    parameter int       CNT_W    = 12
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             run,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             busy
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] VA_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] h_reg, h_next;
    logic [CNT_W-1:0] v_reg, v_next;
    logic [CNT_W-1:0] h_inc;
    logic             row_active;
    logic             de_next;
    logic             req_next;

    // Next position and the decode of that position; outputs are registered
    // from it so every output describes the position held in h_reg/v_reg.
    always_comb begin
        state_next = state_reg;
        h_next     = h_reg;
        v_next     = v_reg;
        case (state_reg)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                    h_next     = '0;
                    v_next     = '0;
                end
            end
            RUN: begin
                if (h_reg == H_LAST) begin
                    h_next = '0;
                    if (v_reg == V_LAST) begin
                        // Only the frame boundary looks at run.
                        v_next = '0;
                        if (!run) begin
                            state_next = IDLE;
                        end
                    end else begin
                        v_next = v_reg + 1'b1;
                    end
                end else begin
                    h_next = h_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                h_next     = '0;
                v_next     = '0;
            end
        endcase

        // The request looks one column ahead on the same line; the back
        // porch guarantees de never starts at h=0.
        h_inc      = h_next + 1'b1;
        row_active = (v_next >= VA_START) && (v_next < VA_END);
        de_next    = (state_next == RUN) && row_active &&
                     (h_next >= HA_START) && (h_next < HA_END);
        req_next   = (state_next == RUN) && row_active &&
                     (h_inc >= HA_START) && (h_inc < HA_END);
    end

    // State, position and all output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg   <= IDLE;
            h_reg       <= '0;
            v_reg       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_reg <= state_next;
            h_reg     <= h_next;
            v_reg     <= v_next;
            if (state_next == RUN) begin
                hsync       <= (h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
                vsync       <= (v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
                de          <= de_next;
                pix_req     <= req_next;
                pix_x       <= req_next ? (h_inc - HA_START) : '0;
                pix_y       <= req_next ? (v_next - VA_START) : '0;
                frame_start <= (h_next == '0) && (v_next == '0);
                busy        <= 1'b1;
            end else begin
                hsync       <= ~SYNC_POL;
                vsync       <= ~SYNC_POL;
                de          <= 1'b0;
                pix_req     <= 1'b0;
                pix_x       <= '0;
                pix_y       <= '0;
                frame_start <= 1'b0;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tmds_timing_ctrl.sv
// Bench for tmds_timing_ctrl on a small 16x8 raster: constant vector table,
// hand-written run-drop and async-reset sequences, and random run toggling
// checked every cycle against a frame-index reference model.
module tb_tmds_timing_ctrl;

    localparam int HS = 4, HB = 2, HA = 8, HF = 2;
    localparam int VS = 2, VB = 1, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;   // 16
    localparam int VT = VS + VB + VA + VF;   // 8
    localparam int FRAME = HT * VT;          // 128
    localparam int CW = 12;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          run     = 1'b0;

    logic          hsync, vsync, de, pix_req, frame_start, busy;
    logic [CW-1:0] pix_x, pix_y;
    logic          hsync1, vsync1, de1, pix_req1, frame_start1, busy1;
    logic [CW-1:0] pix_x1, pix_y1;

    tmds_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SYNC_POL(1'b0), .CNT_W(CW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run),
        .hsync(hsync), .vsync(vsync), .de(de), .pix_req(pix_req),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .busy(busy)
    );

    tmds_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SYNC_POL(1'b1), .CNT_W(CW)
    ) dut_pol1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run),
        .hsync(hsync1), .vsync(vsync1), .de(de1), .pix_req(pix_req1),
        .pix_x(pix_x1), .pix_y(pix_y1), .frame_start(frame_start1), .busy(busy1)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: running flag plus cycle index within the frame.
    bit m_run = 1'b0;
    int m_t   = 0;

    typedef struct {
        int   h;
        int   v;
        logic hs, vs, de, req, fs;
        int   x, y;
    } vec_t;

    vec_t tbl[14];

    function automatic bit is_de(input int t);
        int h, v;
        h = t % HT;
        v = t / HT;
        return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d run=%0b)", name, act, exp, m_t, m_run);
        end
    endtask

    task automatic model_step(input logic r);
        if (!m_run) begin
            if (r) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else if (m_t == FRAME - 1) begin
            if (r) m_t = 0;
            else   m_run = 1'b0;
        end else begin
            m_t++;
        end
    endtask

    task automatic check_model();
        logic e_hs, e_vs, e_de, e_req, e_fs, e_busy;
        logic [CW-1:0] e_x, e_y;
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_req = 1'b0;
        e_fs = 1'b0; e_busy = 1'b0; e_x = '0; e_y = '0;
        if (m_run) begin
            e_busy = 1'b1;
            e_hs   = ((m_t % HT) < HS) ? 1'b0 : 1'b1;
            e_vs   = ((m_t / HT) < VS) ? 1'b0 : 1'b1;
            e_de   = is_de(m_t);
            e_fs   = (m_t == 0);
            e_req  = (m_t + 1 < FRAME) && is_de(m_t + 1);
            if (e_req) begin
                e_x = CW'((m_t + 1) % HT - (HS + HB));
                e_y = CW'((m_t + 1) / HT - (VS + VB));
            end
        end
        check("model_pol0",
              64'({hsync, vsync, de, pix_req, frame_start, busy, pix_x, pix_y}),
              64'({e_hs, e_vs, e_de, e_req, e_fs, e_busy, e_x, e_y}));
        check("model_pol1",
              64'({hsync1, vsync1, de1, pix_req1, frame_start1, busy1, pix_x1, pix_y1}),
              64'({~e_hs, ~e_vs, e_de, e_req, e_fs, e_busy, e_x, e_y}));
    endtask

    task automatic tick(input logic r);
        run = r;
        @(posedge sys_clk);
        if (!sys_rst) model_step(r);
        #1;
        check_model();
    endtask

    task automatic advance_to(input int target);
        int n;
        n = 0;
        while (!(m_run && m_t == target) && n < 400) begin
            tick(1'b1);
            n++;
        end
        check("advance_bound", 64'(n < 400), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int de_cnt, fs_cnt, last_fs;
        logic r;

        //                 h   v  hs vs de req fs  x  y
        tbl[0]  = '{ 0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{ 3, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{ 4, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{ 5, 2, 1, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{ 5, 3, 1, 1, 0, 1, 0, 0, 0};
        tbl[5]  = '{ 6, 3, 1, 1, 1, 1, 0, 1, 0};
        tbl[6]  = '{12, 3, 1, 1, 1, 1, 0, 7, 0};
        tbl[7]  = '{13, 3, 1, 1, 1, 0, 0, 0, 0};
        tbl[8]  = '{ 5, 6, 1, 1, 0, 1, 0, 0, 3};
        tbl[9]  = '{12, 6, 1, 1, 1, 1, 0, 7, 3};
        tbl[10] = '{13, 6, 1, 1, 1, 0, 0, 0, 0};
        tbl[11] = '{14, 6, 1, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{ 6, 7, 1, 1, 0, 0, 0, 0, 0};
        tbl[13] = '{15, 7, 1, 1, 0, 0, 0, 0, 0};

        // Reset state.
        #12;
        check("reset_state",
              64'({hsync, vsync, de, pix_req, frame_start, busy, pix_x, pix_y}),
              64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0}));
        $display("reset values checked");
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("idle_busy", 64'(busy), 64'(0));

        // Two clean frames: table vectors, de count, frame_start spacing.
        de_cnt = 0; fs_cnt = 0; last_fs = -1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick(1'b1);
            if (de) de_cnt++;
            if (frame_start) begin
                fs_cnt++;
                last_fs = c;
            end
            if (c < FRAME) begin
                for (int k = 0; k < 14; k++) begin
                    if (tbl[k].v * HT + tbl[k].h == c) begin
                        check($sformatf("table_h%0d_v%0d", tbl[k].h, tbl[k].v),
                              64'({hsync, vsync, de, pix_req, frame_start, pix_x, pix_y}),
                              64'({tbl[k].hs, tbl[k].vs, tbl[k].de, tbl[k].req, tbl[k].fs,
                                   CW'(tbl[k].x), CW'(tbl[k].y)}));
                        $display("vector h=%0d v=%0d hs=%0b vs=%0b de=%0b req=%0b x=%0d y=%0d",
                                 tbl[k].h, tbl[k].v, hsync, vsync, de, pix_req, pix_x, pix_y);
                    end
                end
            end
        end
        check("de_count_2frames", 64'(de_cnt), 64'(2 * HA * VA));
        check("frame_start_count", 64'(fs_cnt), 64'(2));
        check("frame_start_period", 64'(last_fs), 64'(FRAME));
        $display("two frames: de=%0d frame_starts=%0d", de_cnt, fs_cnt);

        // Drop run at (7,2): the frame must finish before going idle.
        advance_to(2 * HT + 7);
        for (int i = 0; i < FRAME - 1 - (2 * HT + 7); i++) tick(1'b0);
        check("drop_last_pos_busy", 64'(busy), 64'(1));
        tick(1'b0);
        check("drop_idle",
              64'({busy, hsync, vsync, de}), 64'({1'b0, 1'b1, 1'b1, 1'b0}));
        tick(1'b0);
        tick(1'b1);
        check("restart_frame_start", 64'({frame_start, busy}), 64'({1'b1, 1'b1}));
        $display("run drop sequence done");

        // Asynchronous reset at (9,4) while de=1.
        advance_to(4 * HT + 9);
        check("pre_reset_de", 64'(de), 64'(1));
        #3;
        sys_rst = 1'b1;
        #1;
        check("async_reset",
              64'({hsync, vsync, de, pix_req, frame_start, busy, pix_x, pix_y}),
              64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0}));
        m_run = 1'b0;
        m_t   = 0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        check_model();
        sys_rst = 1'b0;
        tick(1'b1);
        check("post_reset_start", 64'({frame_start, hsync, vsync, busy}),
              64'({1'b1, 1'b0, 1'b0, 1'b1}));
        $display("async reset sequence done");

        // Random run toggling against the model.
        r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) r = ~r;
            tick(r);
        end
        $display("random phase done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmds_timing_ctrl.md
Name: tmds_timing_ctrl

Overview:
- Video timing sequencer for the HDMI/TMDS path. Generates hsync, vsync and de; these drive the c0, c1 and de inputs of the blue-channel encoder, and the de input of the other two encoders.
- Issues pixel requests with x/y coordinates one cycle ahead of de, so a registered pixel source can deliver data_in aligned with de.
- Runs on the 25 MHz pixel clock. Starts and stops only on frame boundaries.

Parameters:
- H_SYNC, 96, hsync width in clocks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, active lines
- V_FRONT, 10, vertical front porch
- SYNC_POL, 0, asserted sync level (0 = active-low)
- CNT_W, 12, width of the counters and coordinates

Ports:
- sys_clk  in  1  pixel clock, 25 MHz
- sys_rst  in  1  asynchronous reset, active-high
- run  in  1  1 = generate frames; 0 = stop at the end of the current frame
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- de  out  1  active-video enable
- pix_req  out  1  the pixel at pix_x/pix_y is needed next cycle
- pix_x  out  CNT_W  column of the requested pixel
- pix_y  out  CNT_W  row of the requested pixel
- frame_start  out  1  one-cycle pulse at position (0,0)
- busy  out  1  1 while in state RUN

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT. Region order within a line and within a frame: sync, back porch, active, front porch.
- Reset (asynchronous): state IDLE, h=v=0, hsync=vsync=~SYNC_POL, de=0, pix_req=0, pix_x=pix_y=0, frame_start=0, busy=0.
- States:
  - IDLE: on an edge with run=1, go to RUN; position (0,0) is presented in the following cycle.
  - RUN: h increments every clock. At h=H_TOTAL-1, h wraps to 0 and v increments.
  - At (H_TOTAL-1, V_TOTAL-1), the next state is sampled from run: run=1 wraps to (0,0) in RUN; run=0 goes to IDLE.
  - Deasserting run mid-frame never truncates the frame.
- All outputs are registered. In each RUN cycle they describe the current position (h,v):
  - hsync = SYNC_POL when h < H_SYNC.
  - vsync = SYNC_POL when v < V_SYNC.
  - de = 1 when H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_ACTIVE and V_SYNC+V_BACK <= v < V_SYNC+V_BACK+V_ACTIVE.
  - frame_start = 1 when h=0 and v=0.
  - busy = 1.
- pix_req is 1 in exactly the cycle before each de=1 cycle (same frame). In that cycle:
  - pix_x = h+1-(H_SYNC+H_BACK)
  - pix_y = v-(V_SYNC+V_BACK)
  - pix_x and pix_y are 0 whenever pix_req=0.
- pix_req never asserts on the last position of a frame; V_FRONT >= 1 is required.
- IDLE outputs: identical to the reset values.
- Counts per frame: exactly H_ACTIVE de cycles per active line, exactly H_ACTIVE*V_ACTIVE per frame, and frame length exactly H_TOTAL*V_TOTAL clocks.
- Reset asserted mid-frame: immediate return to reset values. After release, the block waits for run as from IDLE.
- Encoder hookup: blue channel c0=hsync, c1=vsync. The controller adds no latency beyond its own output registers; de, hsync and vsync share the same alignment.

Test Plan:
- Small parameters H=4/2/8/2, V=2/1/4/1, SYNC_POL=0, run=1 after reset release:
  - frame_start pulses every 128 clocks.
  - hsync=0 for h=0..3 each line; vsync=0 for v=0..1.
  - de=1 for h=6..13 on v=3..6.
  - 32 de cycles per frame.
- Same parameters, request alignment:
  - pix_req high at h=5..12; pix_x=0..7; pix_y=0 on v=3 and 3 on v=6.
  - Every de=1 cycle is preceded by pix_req=1; no pix_req occurs outside that pattern.
- run dropped at (h=7, v=2):
  - The frame continues to (15,7), then enters IDLE: busy=0, hsync=vsync=1, de=0.
  - Re-raising run restarts at (0,0) with a frame_start pulse.
- Reset asserted at (h=9, v=4) while de=1:
  - Outputs return to reset values asynchronously, before the next sys_clk edge.
  - With run held 1, the first post-release frame starts cleanly at (0,0).
- Default 640x480 parameters:
  - Frame period is 420000 clocks.
  - First de is at h=144, v=35; last de is at h=783, v=514.
  - 307200 de cycles per frame.
- SYNC_POL=1: hsync and vsync are inverted relative to the SYNC_POL=0 run; de and pix_req are unchanged.
